// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin between the ALU and load producers, formats load
// data, and drives the register-file write port from registered outputs.
module wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_rd,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [4:0]       ld_rd,
    input  logic [2:0]       ld_funct3,
    input  logic [1:0]       ld_addr_lo,
    input  logic [XLEN-1:0]  ld_word,
    output logic [4:0]       a3,
    output logic             we3,
    output logic [XLEN-1:0]  wd3,
    output logic             ld_err,
    output logic [CNT_W-1:0] wb_count
);

    logic             prio_q;
    logic [4:0]       a3_q;
    logic             we3_q;
    logic [XLEN-1:0]  wd3_q;
    logic             ld_err_q;
    logic [CNT_W-1:0] wb_count_q;

    logic             both_valid;
    logic             alu_fire;
    logic             ld_fire;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [XLEN-1:0]  ld_data;
    logic             ld_rsvd;

    // prio_q = 1 means the load path wins a tie.
    assign both_valid = alu_valid & ld_valid;
    assign alu_ready  = ~both_valid | ~prio_q;
    assign ld_ready   = ~both_valid | prio_q;
    assign alu_fire   = alu_valid & alu_ready;
    assign ld_fire    = ld_valid & ld_ready;

    assign ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
    assign ld_half = ld_word[{ld_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = ld_word;
        ld_rsvd = 1'b0;
        case (ld_funct3)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            3'b010:  ld_data = ld_word;
            default: ld_rsvd = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q     <= 1'b1;
            a3_q       <= '0;
            we3_q      <= 1'b0;
            wd3_q      <= '0;
            ld_err_q   <= 1'b0;
            wb_count_q <= '0;
        end else begin
            we3_q    <= 1'b0;
            ld_err_q <= 1'b0;
            if (alu_fire) begin
                a3_q   <= alu_rd;
                wd3_q  <= alu_result;
                we3_q  <= (alu_rd != 5'd0);
                prio_q <= 1'b1;
            end else if (ld_fire) begin
                a3_q     <= ld_rd;
                wd3_q    <= ld_data;
                we3_q    <= (ld_rd != 5'd0);
                ld_err_q <= ld_rsvd;
                prio_q   <= 1'b0;
            end
            if (we3_q) begin
                wb_count_q <= wb_count_q + CNT_W'(1);
            end
        end
    end

    assign a3       = a3_q;
    assign we3      = we3_q;
    assign wd3      = wd3_q;
    assign ld_err   = ld_err_q;
    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: scoreboard of expected register-file writes.
module tb_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alu_valid, ld_valid;
    logic             alu_ready, ld_ready;
    logic [4:0]       alu_rd, ld_rd;
    logic [XLEN-1:0]  alu_result, ld_word;
    logic [2:0]       ld_funct3;
    logic [1:0]       ld_addr_lo;
    logic [4:0]       a3;
    logic             we3;
    logic [XLEN-1:0]  wd3;
    logic             ld_err;
    logic [CNT_W-1:0] wb_count;

    typedef struct packed {
        logic [4:0]  a3;
        logic        we3;
        logic [31:0] wd3;
        logic        err;
    } wr_t;

    wr_t        sb[$];
    logic       grants[$];
    wr_t        m_out;
    logic       m_prio;
    logic [3:0] m_cnt;
    int         n_checks = 0;
    int         n_fail   = 0;

    wb_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
        .ld_addr_lo(ld_addr_lo), .ld_word(ld_word),
        .a3(a3), .we3(we3), .wd3(wd3), .ld_err(ld_err), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [2:0] f, input logic [1:0] lo, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (lo * 8)) & 32'hFF;
        h = (w >> (lo[1] * 16)) & 32'hFFFF;
        case (f)
            3'b000:  return b[7]  ? (b | 32'hFFFFFF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        logic ar, lr, af, lf;
        wr_t  e, got;
        #1;
        ar = !(alu_valid && ld_valid) || !m_prio;
        lr = !(alu_valid && ld_valid) || m_prio;
        check_val("alu_ready", alu_ready, ar);
        check_val("ld_ready", ld_ready, lr);
        af = alu_valid && ar;
        lf = ld_valid && lr && !af;
        e = m_out;
        e.we3 = 1'b0;
        e.err = 1'b0;
        if (af) begin
            e.a3 = alu_rd; e.wd3 = alu_result; e.we3 = (alu_rd != 0);
            m_prio = 1'b1; grants.push_back(1'b0);
        end else if (lf) begin
            e.a3 = ld_rd; e.wd3 = fmt(ld_funct3, ld_addr_lo, ld_word); e.we3 = (ld_rd != 0);
            e.err = ld_funct3 inside {3'b011, 3'b110, 3'b111};
            m_prio = 1'b0; grants.push_back(1'b1);
        end
        sb.push_back(e);
        @(posedge clk);
        m_cnt = m_cnt + {3'b000, m_out.we3};
        @(negedge clk);
        got = sb.pop_front();
        m_out = got;
        check_val("a3", a3, got.a3);
        check_val("we3", we3, got.we3);
        check_val("wd3", wd3, got.wd3);
        check_val("ld_err", ld_err, got.err);
        check_val("wb_count", wb_count, m_cnt);
        $display("txn alu=%0b ld=%0b a3=%0d we3=%0b wd3=0x%08h err=%0b cnt=%0d",
                 af, lf, a3, we3, wd3, ld_err, wb_count);
    endtask

    task automatic idle();
        alu_valid = 1'b0; ld_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        #1;
        check_val("rst_we3", we3, 0);
        check_val("rst_a3", a3, 0);
        check_val("rst_wd3", wd3, 0);
        check_val("rst_cnt", wb_count, 0);
        check_val("rst_err", ld_err, 0);
        check_val("rst_alu_ready", alu_ready, 1);
        check_val("rst_ld_ready", ld_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_prio = 1'b1; m_cnt = '0; m_out = '0;
        sb.delete(); grants.delete();
    endtask

    task automatic alu_req(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1; alu_rd = rd; alu_result = d;
    endtask

    task automatic ld_req(input logic [4:0] rd, input logic [2:0] f, input logic [1:0] lo, input logic [31:0] w);
        ld_valid = 1'b1; ld_rd = rd; ld_funct3 = f; ld_addr_lo = lo; ld_word = w;
    endtask

    localparam logic [2:0] F3 [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b111, 3'b011, 3'b110};
    localparam logic [1:0] LO [8] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1};

    initial begin
        logic [3:0] exp_g;
        rst_n = 1'b0;
        idle();
        alu_rd = '0; alu_result = '0; ld_rd = '0; ld_funct3 = '0; ld_addr_lo = '0; ld_word = '0;
        @(negedge clk);
        do_reset();

        // Single ALU write
        alu_req(5'd5, 32'hDEADBEEF);
        step();
        idle();
        step();

        // Load formatting, including reserved funct3 encodings
        for (int i = 0; i < 8; i++) begin
            ld_req(5'(i + 8), F3[i], LO[i], 32'h80FF7F01);
            step();
            idle();
            step();
        end

        // Reset mid-operation while we3 is high
        alu_req(5'd9, 32'h12345678);
        step();
        check_val("pre_rst_we3", we3, 1);
        do_reset();

        // Contention from reset: LOAD, ALU, LOAD, ALU
        for (int i = 0; i < 4; i++) begin
            alu_req(5'(1 + i), 32'hA000_0000 + i);
            ld_req(5'(1 + i), 3'b010, 2'd0, 32'hB000_0000 + i);
            step();
        end
        idle();
        step();
        exp_g = 4'b0101;
        check_val("grant_cnt", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) check_val("grant_order", grants[i], exp_g[i]);
        end

        // x0 suppression
        alu_req(5'd0, 32'hFFFF_FFFF);
        step();
        idle();
        step();

        // Counter wrap: 17 writes from reset leave a 4-bit count at 1
        do_reset();
        for (int i = 0; i < 17; i++) begin
            alu_req(5'(1 + (i % 31)), 32'(i));
            step();
        end
        idle();
        step();
        check_val("wrap", wb_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
